// File: rtl/aes_pkg.sv
// aes_pkg: FSM state encoding, round-count function, GF(2^8) helpers and state byte-index helpers
// shared by aes_cipher_core, aes_round and the S-boxes (field polynomial 0x11B).
package aes_pkg;
    typedef logic [1:0] aes_state_t;
    localparam aes_state_t IDLE   = 2'd0;
    localparam aes_state_t ADDKEY = 2'd1;
    localparam aes_state_t ROUND  = 2'd2;
    localparam aes_state_t DONE   = 2'd3;

    function automatic int aes_nr(input int key_bits);
        return key_bits == 256 ? 14 : key_bits == 192 ? 12 : 10;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return xt(b);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int k = 0; k < 8; k++) begin
            r = b[k] ? r ^ p : r;
            p = xt(p);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int k = 0; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic int byte_lsb(input int i);
        return 120 - 8 * i;
    endfunction

    function automatic int sr_src(input int i);
        return 4 * ((i / 4 + i % 4) % 4) + i % 4;
    endfunction

    function automatic int isr_src(input int i);
        return 4 * ((i / 4 + 4 - i % 4) % 4) + i % 4;
    endfunction

    function automatic int col_nb(input int i, input int k);
        return 4 * (i / 4) + (i + k) % 4;
    endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: inverse AES S-box, inverse affine transform followed by the GF(2^8) inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] u;
    assign u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(u);
endmodule

// File: rtl/aes_round.sv
// aes_round: one combinational AES round; inverse path always, forward path only with AES_ENCRYPT_EN.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         mode,
    input  logic         last,
    output logic [127:0] result
);
    logic [7:0]   isb [16];
    logic [7:0]   ak  [16];
    logic [127:0] dec;

    for (genvar i = 0; i < 16; i++) begin : g_dec
        aes_inv_sbox u_isb (.a(state[byte_lsb(isr_src(i)) +: 8]), .y(isb[i]));
        assign ak[i] = isb[i] ^ rk[byte_lsb(i) +: 8];
        assign dec[byte_lsb(i) +: 8] = last ? ak[i] :
            gm14(ak[i]) ^ gm11(ak[col_nb(i, 1)]) ^ gm13(ak[col_nb(i, 2)]) ^ gm9(ak[col_nb(i, 3)]);
    end

`ifdef AES_ENCRYPT_EN
    logic [7:0]   sb [16];
    logic [127:0] enc;

    for (genvar i = 0; i < 16; i++) begin : g_enc
        aes_sbox u_sb (.a(state[byte_lsb(sr_src(i)) +: 8]), .y(sb[i]));
        assign enc[byte_lsb(i) +: 8] = rk[byte_lsb(i) +: 8] ^ (last ? sb[i] :
            gm2(sb[i]) ^ gm3(sb[col_nb(i, 1)]) ^ sb[col_nb(i, 2)] ^ sb[col_nb(i, 3)]);
    end

    assign result = mode ? enc : dec;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign result = dec;
`endif
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box, GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] v;
    assign v = gf_inv(a);
    assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES, one round per clock, round keys fetched through rk_idx_out/rk_in.
// Decrypt-only unless AES_ENCRYPT_EN is defined, which adds encrypt selected by mode_in.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int NR = aes_nr(KEY_BITS)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         in_valid_in,
    output logic         in_ready_out,
    input  logic         mode_in,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx_out,
    input  logic [127:0] rk_in,
    output logic         out_valid_out,
    input  logic         out_ready_in,
    output logic [127:0] data_out
);
    localparam logic [3:0] NR4 = 4'(NR);

    aes_state_t   st;
    logic [3:0]   cnt;
    logic         mode_q, mode_acc, last;
    logic [127:0] blk, rnd_out;

`ifdef AES_ENCRYPT_EN
    assign mode_acc = mode_in;
`else
    logic unused_mode_in;
    assign unused_mode_in = mode_in;
    assign mode_acc = 1'b0;
`endif

    assign last          = cnt == NR4;
    assign in_ready_out  = rst_in && st == IDLE;
    assign out_valid_out = st == DONE;
    assign data_out      = blk;
    assign rk_idx_out    = st == ADDKEY ? (mode_q ? 4'd0 : NR4) :
                           st == ROUND  ? (mode_q ? cnt : NR4 - cnt) : 4'd0;

    aes_round u_round (.state(blk), .rk(rk_in), .mode(mode_q), .last(last), .result(rnd_out));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            st     <= IDLE;
            cnt    <= 4'd0;
            mode_q <= 1'b0;
            blk    <= '0;
        end else begin
            case (st)
                IDLE: if (in_valid_in) begin
                    blk    <= data_in;
                    mode_q <= mode_acc;
                    st     <= ADDKEY;
                end
                ADDKEY: begin
                    blk <= blk ^ rk_in;
                    cnt <= 4'd1;
                    st  <= ROUND;
                end
                ROUND: begin
                    blk <= rnd_out;
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    st  <= last ? DONE : ROUND;
                end
                default: if (out_ready_in) st <= IDLE;
            endcase
        end
    end
endmodule
